// File: rtl/mcdf_pkg.sv
// Shared types and helpers for the MCDF arbiter family.
// Length codes, decode function and arbiter state encoding.
package mcdf_pkg;

    localparam logic [1:0] LEN_4  = 2'd0;
    localparam logic [1:0] LEN_8  = 2'd1;
    localparam logic [1:0] LEN_16 = 2'd2;
    localparam logic [1:0] LEN_32 = 2'd3;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    function automatic logic [5:0] len_decode(input logic [31:0] code);
        logic [5:0] len;
        len = 6'd32;
        unique case (1'b1)
            (code == 32'(LEN_4)):  len = 6'd4;
            (code == 32'(LEN_8)):  len = 6'd8;
            (code == 32'(LEN_16)): len = 6'd16;
            default:               len = 6'd32;
        endcase
        return len;
    endfunction

endpackage

// File: rtl/mcdf_rr_prio_pick.sv
// Combinational picker: lowest priority value wins,
// ties broken round-robin starting after i_rr_ptr.
module mcdf_rr_prio_pick
    import mcdf_pkg::*;
#(
    parameter int NUM_CH = 3,
    parameter int PRIO_W = 2,
    parameter int CHID_W = 2
) (
    input  logic [NUM_CH-1:0]        i_cand,
    input  logic [NUM_CH*PRIO_W-1:0] i_prio,
    input  logic [CHID_W-1:0]        i_rr_ptr,
    output logic [CHID_W-1:0]        o_grant,
    output logic                     o_found
);

    logic [PRIO_W-1:0] w_min_prio;

    // smallest priority value among all candidates
    always_comb begin
        w_min_prio = '1;
        for (int i = 0; i < NUM_CH; i++) begin
            if (i_cand[i] && (i_prio[i*PRIO_W +: PRIO_W] < w_min_prio)) begin
                w_min_prio = i_prio[i*PRIO_W +: PRIO_W];
            end
        end
    end

    // nearest candidate at that priority, searching up from rr_ptr+1
    always_comb begin
        int w_dist;
        int w_best;
        w_dist  = 0;
        w_best  = NUM_CH;
        o_grant = '0;
        o_found = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (i > int'(i_rr_ptr)) begin
                w_dist = i - int'(i_rr_ptr) - 1;
            end else begin
                w_dist = i + NUM_CH - int'(i_rr_ptr) - 1;
            end
            if (i_cand[i] &&
                (i_prio[i*PRIO_W +: PRIO_W] == w_min_prio) &&
                (w_dist < w_best)) begin
                w_best  = w_dist;
                o_grant = CHID_W'(i);
                o_found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mcdf_arbiter_n.sv
// N-channel packet arbiter between slave FIFOs and formatter.
// Grants by priority with round-robin tie-break, locks for a packet.
module mcdf_arbiter_n
    import mcdf_pkg::*;
#(
    parameter int NUM_CH = 3,
    parameter int DATA_W = 32,
    parameter int PRIO_W = 2,
    parameter int LEN_W  = 3,
    parameter int CHID_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_CH-1:0]        ch_en,
    input  logic [NUM_CH-1:0]        ch_valid,
    input  logic [NUM_CH*DATA_W-1:0] ch_data,
    input  logic [NUM_CH*PRIO_W-1:0] ch_prio,
    input  logic [NUM_CH*LEN_W-1:0]  ch_len,
    output logic [NUM_CH-1:0]        ch_ready,
    input  logic                     out_ready,
    output logic                     out_valid,
    output logic [DATA_W-1:0]        out_data,
    output logic [CHID_W-1:0]        out_chid,
    output logic                     out_sop,
    output logic                     out_eop
);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CHID_W-1:0] r_sel;
    logic [CHID_W-1:0] w_sel_nxt;
    logic [5:0]        r_len;
    logic [5:0]        w_len_nxt;
    logic [5:0]        r_beat_cnt;
    logic [5:0]        w_cnt_nxt;
    logic [CHID_W-1:0] r_rr_ptr;
    logic [CHID_W-1:0] w_rr_nxt;

    logic [NUM_CH-1:0] w_cand;
    logic [CHID_W-1:0] w_grant;
    logic              w_found;
    logic [LEN_W-1:0]  w_len_code;
    logic              w_sel_ok;
    logic [DATA_W-1:0] w_sel_data;
    logic              w_bvalid;
    logic              w_xfer;
    logic              w_last;

    assign w_cand   = ch_en & ch_valid;
    assign w_bvalid = (r_state == BURST) && w_sel_ok;
    assign w_xfer   = w_bvalid && out_ready;
    assign w_last   = (r_beat_cnt == (r_len - 6'd1));

    mcdf_rr_prio_pick #(
        .NUM_CH (NUM_CH),
        .PRIO_W (PRIO_W),
        .CHID_W (CHID_W)
    ) u_pick (
        .i_cand   (w_cand),
        .i_prio   (ch_prio),
        .i_rr_ptr (r_rr_ptr),
        .o_grant  (w_grant),
        .o_found  (w_found)
    );

    // length code of the channel about to be granted
    always_comb begin
        w_len_code = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (w_grant == CHID_W'(i)) begin
                w_len_code = ch_len[i*LEN_W +: LEN_W];
            end
        end
    end

    // enable/valid and data head of the locked channel
    always_comb begin
        w_sel_ok   = 1'b0;
        w_sel_data = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (r_sel == CHID_W'(i)) begin
                w_sel_ok   = ch_en[i] && ch_valid[i];
                w_sel_data = ch_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // state and grant registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_sel      <= '0;
            r_len      <= '0;
            r_beat_cnt <= '0;
            r_rr_ptr   <= CHID_W'(NUM_CH - 1);
        end else begin
            r_state    <= w_state_nxt;
            r_sel      <= w_sel_nxt;
            r_len      <= w_len_nxt;
            r_beat_cnt <= w_cnt_nxt;
            r_rr_ptr   <= w_rr_nxt;
        end
    end

    // arbitration in IDLE, beat counting and release in BURST
    always_comb begin
        w_state_nxt = r_state;
        w_sel_nxt   = r_sel;
        w_len_nxt   = r_len;
        w_cnt_nxt   = r_beat_cnt;
        w_rr_nxt    = r_rr_ptr;
        unique case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_state_nxt = BURST;
                    w_sel_nxt   = w_grant;
                    w_len_nxt   = len_decode(32'(w_len_code));
                    w_cnt_nxt   = '0;
                end
            end
            BURST: begin
                if (w_xfer) begin
                    if (w_last) begin
                        w_state_nxt = IDLE;
                        w_rr_nxt    = r_sel;
                    end else begin
                        w_cnt_nxt = r_beat_cnt + 6'd1;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // beat outputs; everything is zero outside a burst
    always_comb begin
        out_valid = w_bvalid;
        out_data  = w_bvalid ? w_sel_data : '0;
        out_chid  = (r_state == BURST) ? r_sel : '0;
        out_sop   = w_bvalid && (r_beat_cnt == 6'd0);
        out_eop   = w_bvalid && w_last;
        ch_ready  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            ch_ready[i] = w_xfer && (r_sel == CHID_W'(i));
        end
    end

endmodule

// File: doc/mcdf_arbiter_n.md
Name: mcdf_arbiter_n

Overview:
- N-channel, packet-granular arbiter. Generalised successor of the fixed 3-channel MCDF arbiter.
- Sits between the per-channel slave FIFOs and the formatter.
- Picks one channel by programmable priority, with round-robin tie-break, and holds that grant for a full packet whose length comes from the channel's length register.
- Adds channel count, width parameters, SOP/EOP marking and backpressure-safe burst locking.

Parameters:
- NUM_CH, 3, number of channels (2..16).
- DATA_W, 32, data width per channel.
- PRIO_W, 2, priority field width; value 0 is the highest priority.
- LEN_W, 3, packet length code width.
- CHID_W, $clog2(NUM_CH) with minimum 1, channel id width.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- ch_en  in  NUM_CH  per-channel enable from the register block.
- ch_valid  in  NUM_CH  FIFO non-empty / data valid, one bit per channel.
- ch_data  in  NUM_CH*DATA_W  packed FIFO heads; channel i at [i*DATA_W +: DATA_W].
- ch_prio  in  NUM_CH*PRIO_W  packed priorities.
- ch_len  in  NUM_CH*LEN_W  packed length codes.
- ch_ready  out  NUM_CH  pop strobe to each FIFO.
- out_ready  in  1  downstream (formatter) accepts a beat.
- out_valid  out  1  beat valid.
- out_data  out  DATA_W  beat data.
- out_chid  out  CHID_W  granted channel id.
- out_sop  out  1  first beat of packet.
- out_eop  out  1  last beat of packet.

Behaviour:
- Reset (async, rst_n low): state=IDLE, sel=0, beat_cnt=0, rr_ptr=NUM_CH-1.
  - While in reset all outputs are 0: ch_ready, out_valid, out_sop, out_eop, out_data, out_chid.
  - Reset mid-burst abandons the packet; no further pops.
- Candidates: channel i is a candidate when ch_en[i] && ch_valid[i].
- Length decode, registered at grant: code 0→4, 1→8, 2→16, 3 and above→32 beats.
  - beat_cnt is 6 bits and counts 0..len-1.
- State IDLE:
  - If any candidate exists, find the minimum ch_prio among candidates.
  - Among candidates at that priority, pick the first one found searching from (rr_ptr+1) mod NUM_CH upward, wrapping.
  - Latch sel, the decoded length and beat_cnt=0, then go to BURST. This costs one arbitration cycle; no beat is issued in IDLE.
- State BURST:
  - out_chid = sel.
  - out_valid = ch_valid[sel] && ch_en[sel].
  - out_data = ch_data[sel]. It is muxed combinationally and is 0 when out_valid is low.
  - ch_ready[sel] = out_valid && out_ready; all other ch_ready bits are 0.
  - xfer = out_valid && out_ready.
  - out_sop = out_valid && beat_cnt==0.
  - out_eop = out_valid && beat_cnt==len-1.
  - On xfer that is not the last beat: beat_cnt+1.
  - On xfer of the last beat: rr_ptr=sel and go to IDLE.
  - Backpressure: with out_ready low, beat_cnt, sel and data are held.
  - Valid gap: with ch_valid[sel] low, out_valid is low and the grant is kept; other channels are not served.
- Grant lock: ch_prio, ch_len and other channels' valids are ignored during BURST. Changes take effect at the next IDLE arbitration.
- ch_en[sel] dropping mid-burst: out_valid is forced low and the grant is held until re-enabled.
- Single candidate: it wins regardless of rr_ptr.
- Back-to-back packets from the same channel are allowed when it is the only candidate. Each packet costs len+1 cycles minimum.

Decomposition:
- Shared package mcdf_pkg holds:
  - the length-code constants LEN_4=0, LEN_8=1, LEN_16=2, LEN_32=3;
  - the decode function len_decode(code)→6-bit;
  - the state enum {IDLE, BURST}.
- One sub-module: mcdf_rr_prio_pick. It is combinational and takes candidate mask, packed priorities and rr_ptr; it returns a grant index and a found flag. It is reusable by future N-channel blocks.

Test Plan:
- Basic packet: NUM_CH=3, ch0 only, len code 0, out_ready=1 → one IDLE cycle, then 4 beats on ch0; out_sop on beat 0, out_eop on beat 3, ch_ready[0] high for exactly 4 cycles.
- Strict priority: ch0 prio 2, ch1 prio 0, both valid, len code 0 → ch1 packet first (out_chid=1), then ch0.
- Round-robin tie: ch0, ch1 and ch2 all prio 1 and always valid, len code 0 → packet order 0,1,2,0,1; each packet 4 beats, 5-cycle period.
- Backpressure and valid gap: 8-beat packet on ch2 (code 1); out_ready low for 3 cycles at beat 2; ch_valid[2] low 2 cycles at beat 5 → still exactly 8 xfers, sop/eop placed correctly, no pops on ch0/ch1, data order preserved.
- Reset mid-burst: assert rst_n low at beat 10 of a 32-beat packet (code 3) → outputs 0 immediately (asynchronously); after release, next grant starts from ch0 with out_sop on its first beat.
- NUM_CH=8, DATA_W=16: channels 3 and 7 valid at equal prio, rr_ptr=3 → ch7 granted first, out_chid=3'd7.
